serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder built around a single instance of the team's one-bit `FULL_ADDER` cell. The block sequences that cell LSB-first over `WIDTH` clock cycles and holds the running carry in a flip-flop between bits. It presents a start/ready/done handshake to the surrounding combinational design, which gets a multi-bit add at the area cost of one cell plus shift registers.

---
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that sequences one FULL_ADDER cell LSB-first with a registered carry.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output OVF.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cy;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_s_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  FULL_ADDER u_fa (
    .A  (r_a_sh[0]),
    .B  (r_b_sh[0]),
    .CI (r_cy),
    .S  (w_s),
    .CO (w_co)
  );

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
  assign w_s_next = WIDTH'({w_s, r_s_sh} >> 1);

  assign READY = (r_state == ST_IDLE) || (r_state == ST_FIN);
  assign BUSY  = (r_state == ST_RUN);
  assign DONE  = (r_state == ST_FIN);
  assign SUM   = r_sum;
  assign COUT  = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign OVF   = r_ovf;
`endif

  // Control FSM and datapath: load on accept, one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_a_sh  <= {WIDTH{1'b0}};
      r_b_sh  <= {WIDTH{1'b0}};
      r_s_sh  <= {WIDTH{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cy    <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_s_sh  <= {WIDTH{1'b0}};
            r_cy    <= CIN;
            r_cnt   <= {CW{1'b0}};
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_s_sh <= w_s_next;
          r_cy   <= w_co;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
            // r_cy here is the carry into the MSB, w_co the carry out of it.
            r_ovf   <= r_cy ^ w_co;
`endif
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// One-bit full adder cell.
module FULL_ADDER (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): arithmetic model plus directed vectors.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         READY;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .READY (READY),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted add resolves W cycles later to A+B+CIN.
  int         m_left;
  logic       m_done;
  logic [W-1:0] m_sum;
  logic       m_cout;
  logic       m_ovf;
  logic [W:0] m_pend;
  logic       m_pend_ovf;

  function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (START) begin
          m_pend     <= {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CIN};
          m_pend_ovf <= signed_ovf(A, B, CIN);
          m_left     <= W;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_sum  <= m_pend[W-1:0];
          m_cout <= m_pend[W];
          m_ovf  <= m_pend_ovf;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_ready", READY, (m_left == 0));
      chk("cyc_busy",  BUSY,  (m_left != 0));
      chk("cyc_done",  DONE,  m_done);
      chk("cyc_sum",   SUM,   m_sum);
      chk("cyc_cout",  COUT,  m_cout);
`ifdef SERIAL_ADDER_OVF_EN
      chk("cyc_ovf",   OVF,   m_ovf);
`endif
    end
  end

  task automatic step();
    @(negedge CLK);
    if (BUSY) busy_cnt++;
    if (DONE) done_cnt++;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    A = a; B = b; CIN = c; START = 1'b1;
    busy_cnt = 0;
    step(); n = 1;
    START = 1'b0; A = ~a; B = ~b; CIN = ~c;
    while (!DONE && n < 40) begin step(); n++; end
    chk({nm, "_done"}, DONE, 1'b1);
    chk({nm, "_lat"}, n, 9);
    chk({nm, "_busy"}, busy_cnt, 8);
    chk({nm, "_sum"}, SUM, es);
    chk({nm, "_cout"}, COUT, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, OVF, eo);
`else
    if (eo === 1'bx) $display("note: overflow expectation undefined for %s", nm);
`endif
    step();
  endtask

  initial begin
    int n;
    RST_N = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ready", READY, 1'b1);
    chk("rst_busy",  BUSY,  1'b0);
    chk("rst_done",  DONE,  1'b0);
    chk("rst_sum",   SUM,   8'h00);
    chk("rst_cout",  COUT,  1'b0);
    chk_en = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Basic add with an ignored START at E0+3 and operands scrambled after accept
    A = 8'h5A; B = 8'h3C; CIN = 1'b0; START = 1'b1;
    busy_cnt = 0;
    step(); n = 1;
    START = 1'b0; A = 8'hC3; B = 8'h11; CIN = 1'b1;
    step(); n++;
    step(); n++;
    START = 1'b1; A = 8'h00; B = 8'h00; CIN = 1'b0;
    step(); n++;
    START = 1'b0; A = 8'hFF;
    while (!DONE && n < 40) begin step(); n++; end
    chk("basic_done", DONE, 1'b1);
    chk("basic_lat",  n, 9);
    chk("basic_busy", busy_cnt, 8);
    chk("basic_sum",  SUM, 8'h96);
    chk("basic_cout", COUT, 1'b0);
    step();
    chk("basic_done_pulse", DONE, 1'b0);

    run_op("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("mixed",  8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    // Back-to-back with START held high
    A = 8'h5A; B = 8'h3C; CIN = 1'b0; START = 1'b1;
    step(); n = 1;
    A = 8'h77; B = 8'h99; CIN = 1'b1;
    while (!DONE && n < 40) begin step(); n++; end
    chk("b2b_lat1", n, 9);
    chk("b2b_sum1", SUM, 8'h96);
    chk("b2b_cout1", COUT, 1'b0);
    A = 8'h01; B = 8'h02; CIN = 1'b1;
    step(); n++;
    A = 8'h55; B = 8'hAA; CIN = 1'b0;
    while (!DONE && n < 40) begin
      chk("b2b_hold", SUM, 8'h96);
      step(); n++;
    end
    chk("b2b_lat2", n, 18);
    chk("b2b_sum2", SUM, 8'h04);
    chk("b2b_cout2", COUT, 1'b0);
    START = 1'b0;
    step();

    // Asynchronous reset between E0+4 and E0+5
    A = 8'hFF; B = 8'hFF; CIN = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    step(); step(); step();
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_ready", READY, 1'b1);
    chk("mid_rst_busy",  BUSY,  1'b0);
    chk("mid_rst_done",  DONE,  1'b0);
    chk("mid_rst_sum",   SUM,   8'h00);
    chk("mid_rst_cout",  COUT,  1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) step();
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_ready_after", READY, 1'b1);
    chk("mid_rst_sum_after", SUM, 8'h00);

    run_op("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovf0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
